// File: rtl/clock_recovery_pkg.sv
// Shared types for the clock recovery and generation blocks: counter width,
// the recovered clock event struct, the recovery FSM state type and rate helpers.
package clks_alot_p;

  localparam int COUNTER_WIDTH = 16;

  typedef struct packed {
    logic clk_state;
    logic rising_edge;
    logic falling_edge;
  } clock_states_s;

  typedef logic [2:0] recovery_state_e;

  localparam recovery_state_e RS_IDLE    = 3'd0;
  localparam recovery_state_e RS_ACQUIRE = 3'd1;
  localparam recovery_state_e RS_MEASURE = 3'd2;
  localparam recovery_state_e RS_LOCKED  = 3'd3;
  localparam recovery_state_e RS_STALLED = 3'd4;

  // Average half period; the sum needs one extra bit before the shift.
  function automatic logic [COUNTER_WIDTH-1:0] half_period(
    input logic [COUNTER_WIDTH-1:0] hi,
    input logic [COUNTER_WIDTH-1:0] lo
  );
    logic [COUNTER_WIDTH:0] sum;
    sum = {1'b0, hi} + {1'b0, lo};
    return sum[COUNTER_WIDTH:1];
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] half_minus_two(
    input logic [COUNTER_WIDTH-1:0] hi,
    input logic [COUNTER_WIDTH-1:0] lo
  );
    logic [COUNTER_WIDTH-1:0] half;
    half = half_period(hi, lo);
    return (half >= COUNTER_WIDTH'(2)) ? half - COUNTER_WIDTH'(2) : '0;
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] quarter_minus_one(
    input logic [COUNTER_WIDTH-1:0] hi,
    input logic [COUNTER_WIDTH-1:0] lo
  );
    logic [COUNTER_WIDTH-1:0] quarter;
    quarter = half_period(hi, lo) >> 1;
    return (quarter != '0) ? quarter - COUNTER_WIDTH'(1) : '0;
  endfunction

endpackage

// File: rtl/clock_recovery_phase_timer.sv
// Saturating phase-length counter with clear/load and a look-ahead timeout compare,
// so the stall flag rises in the same cycle the counter reaches the limit.
module recovery_phase_timer
  import clks_alot_p::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en_i,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] limit_i,
  output logic [COUNTER_WIDTH-1:0] count_o,
  output logic                     timeout_o
);

  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = COUNTER_WIDTH'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clk_en_i) begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables stall detection entirely.
  assign timeout_o = clk_en_i && !clear_i && !load_i && (limit_i != '0) && (cnt_d >= limit_i);
  assign count_o   = cnt_q;

endmodule

// File: rtl/clock_recovery.sv
// Recovers level, edge events, phase lengths and rate words from an already
// synchronized external clock, with lock, stall and glitch status.
module clock_recovery
  import clks_alot_p::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     enable_i,
  input  logic                     sync_clk_i,
  input  logic [COUNTER_WIDTH-1:0] timeout_limit_i,
  input  logic [COUNTER_WIDTH-1:0] min_phase_i,
  output clock_states_s            actual_clk_state_o,
  output logic [COUNTER_WIDTH-1:0] high_time_o,
  output logic [COUNTER_WIDTH-1:0] low_time_o,
  output logic [COUNTER_WIDTH-1:0] expected_half_rate_minus_two_o,
  output logic [COUNTER_WIDTH-1:0] expected_quarter_rate_minus_one_o,
  output logic                     locked_o,
  output logic                     stalled_o,
  output logic                     glitch_o,
  output recovery_state_e          dbg_state_o
);

  recovery_state_e          state_q, state_d;
  logic                     level_q, level_d;
  logic                     seen_high_q, seen_high_d;
  logic                     seen_low_q, seen_low_d;
  logic [COUNTER_WIDTH-1:0] high_q, high_d;
  logic [COUNTER_WIDTH-1:0] low_q, low_d;
  logic [COUNTER_WIDTH-1:0] half_q, half_d;
  logic [COUNTER_WIDTH-1:0] quarter_q, quarter_d;
  logic [COUNTER_WIDTH-1:0] phase_cnt;
  logic                     timeout;
  logic                     edge_det, measuring, short_phase, glitch, record;

  // Edges are ignored in IDLE so the first sample after enable or reset is silent.
  assign edge_det    = clk_en && enable_i && (state_q != RS_IDLE) && (sync_clk_i != level_q);
  assign measuring   = (state_q == RS_MEASURE) || (state_q == RS_LOCKED);
  assign short_phase = (min_phase_i != '0) && (phase_cnt < min_phase_i);
  assign glitch      = edge_det && measuring && short_phase;
  assign record      = edge_det && measuring && !short_phase;

  recovery_phase_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en_i  (clk_en),
    .clear_i   (!enable_i || (state_q == RS_IDLE)),
    .load_i    (edge_det),
    .limit_i   (timeout_limit_i),
    .count_o   (phase_cnt),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    seen_high_d = seen_high_q;
    seen_low_d  = seen_low_q;
    high_d      = high_q;
    low_d       = low_q;
    half_d      = enable_i ? half_minus_two(high_q, low_q) : '0;
    quarter_d   = enable_i ? quarter_minus_one(high_q, low_q) : '0;
    if (clk_en) begin
      level_d = sync_clk_i;
      if (!enable_i) begin
        state_d     = RS_IDLE;
        high_d      = '0;
        low_d       = '0;
        seen_high_d = 1'b0;
        seen_low_d  = 1'b0;
      end else begin
        case (state_q)
          RS_IDLE: state_d = RS_ACQUIRE;
          RS_ACQUIRE, RS_STALLED: begin
            if (edge_det) begin
              state_d     = RS_MEASURE;
              seen_high_d = 1'b0;
              seen_low_d  = 1'b0;
            end
          end
          RS_MEASURE, RS_LOCKED: begin
            if (glitch) begin
              state_d     = RS_MEASURE;
              seen_high_d = 1'b0;
              seen_low_d  = 1'b0;
            end else if (record) begin
              // A rising edge closes a low phase, a falling edge closes a high phase.
              if (sync_clk_i) begin
                low_d      = phase_cnt;
                seen_low_d = 1'b1;
                if (seen_high_q) state_d = RS_LOCKED;
              end else begin
                high_d      = phase_cnt;
                seen_high_d = 1'b1;
                if (seen_low_q) state_d = RS_LOCKED;
              end
            end else if (timeout) begin
              state_d = RS_STALLED;
            end
          end
          default: state_d = RS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RS_IDLE;
      level_q     <= 1'b0;
      seen_high_q <= 1'b0;
      seen_low_q  <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      half_q      <= '0;
      quarter_q   <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      level_q     <= level_d;
      seen_high_q <= seen_high_d;
      seen_low_q  <= seen_low_d;
      high_q      <= high_d;
      low_q       <= low_d;
      half_q      <= half_d;
      quarter_q   <= quarter_d;
    end
  end

  always_comb begin
    actual_clk_state_o              = '0;
    actual_clk_state_o.clk_state    = level_q;
    actual_clk_state_o.rising_edge  = edge_det && sync_clk_i;
    actual_clk_state_o.falling_edge = edge_det && !sync_clk_i;
  end

  assign high_time_o                       = high_q;
  assign low_time_o                        = low_q;
  assign expected_half_rate_minus_two_o    = half_q;
  assign expected_quarter_rate_minus_one_o = quarter_q;
  assign locked_o                          = (state_q == RS_LOCKED);
  assign stalled_o                         = (state_q == RS_STALLED);
  assign glitch_o                          = glitch;
  assign dbg_state_o                       = state_q;

endmodule
